acq_bank_scheduler: RTL and testbench
=====================================

Name: acq_bank_scheduler

Overview:
- Capture sequencer for the dual-bank ADC sample buffer in the acoustics FPGA.
- Sits between the ADC front end and the buffer's write port, all in the ADC clock domain.
- Arms on a DSP command and starts on an immediate or threshold trigger.
- Gates the buffer write strobe so bank boundaries stay aligned, tracks which banks hold unread data, interrupts the DSP per filled bank, and stalls with an overrun flag when the DSP falls behind.

Parameters:
DEPTH_LOG2, 13, log2 of samples per bank; must match the buffer bank depth.
CNT_W, 8, width of the bank-count request and counter.

Ports:
ADC_I_clk  in  1  single clock; all logic is rising-edge.
I_rst_n  in  1  asynchronous, active-low reset.
CTL_I_arm  in  1  one-cycle pulse; starts a capture sequence.
CTL_I_abort  in  1  one-cycle pulse; stops capture.
CTL_I_trigMode  in  1  0 = immediate start, 1 = threshold start.
CTL_I_threshold  in  16  unsigned magnitude threshold.
CTL_I_numBanks  in  CNT_W  number of banks to capture; 0 = continuous.
ADC_I_dataValid  in  1  sample strobe.
ADC_I_data  in  16  signed two's-complement sample.
BF_I_bankRelease  in  2  one-cycle pulse per bank; DSP has finished reading it (already synchronised to ADC_I_clk).
O_dataValid  out  1  write strobe to the buffer.
O_data  out  16  registered sample to the buffer.
O_bufRst  out  1  active-high one-cycle pulse that zeroes the buffer write counter.
O_bankReady  out  2  level; bank holds complete, unreleased data.
O_irq  out  1  one-cycle pulse on bank completion.
O_irqBank  out  1  bank number qualifying O_irq.
O_state  out  2  current FSM state.
O_overrun  out  1  sticky overrun flag.
O_done  out  1  one-cycle pulse when the requested bank count is complete.

Behaviour:
- Reset (async, I_rst_n=0): all outputs 0, state IDLE, counters 0, current bank 0.
- FSM states: IDLE=00, ARMED=01, CAPTURE=10, STALL=11.
- IDLE:
  - Arm takes effect next cycle: clear O_bankReady, O_overrun, sample index, bank counter and current bank; pulse O_bufRst for one cycle; go to ARMED.
  - Arm outside IDLE is ignored.
- ARMED, trigger sample:
  - trigMode=0: the first ADC_I_dataValid sample.
  - trigMode=1: the first valid sample with |data| >= threshold. |data| is computed 17-bit, so |-32768| = 32768.
  - The trigger sample is written as index 0 of bank 0, and the state goes to CAPTURE in the same cycle.
  - Earlier samples are dropped.
- CAPTURE:
  - Each valid sample produces O_dataValid=1 and O_data=ADC_I_data exactly one cycle later (latency 1, no bubbles).
  - The sample index increments, modulo 2^DEPTH_LOG2.
- Bank completion (write of index 2^DEPTH_LOG2-1), on the cycle after that write strobe:
  - O_irq=1, O_irqBank=current bank, O_bankReady[bank] set, bank counter incremented.
  - If numBanks!=0 and the counter equals numBanks: pulse O_done and go to IDLE.
  - Else toggle the current bank. If the new bank's O_bankReady is still set, go to STALL and set O_overrun; otherwise remain in CAPTURE.
- A valid sample arriving on the completion cycle is written to the new bank if it is free, and dropped if it is not.
- STALL:
  - All samples are dropped and O_dataValid stays 0, so the buffer counter does not advance and remains at the new bank's base.
  - A release pulse for the awaited bank clears its ready bit; the state returns to CAPTURE next cycle and resumes at index 0.
- BF_I_bankRelease[b]:
  - Clears O_bankReady[b] in any state.
  - Ignored if the bit is already clear.
  - If it coincides with the set of the same bit, the set wins.
- Abort, from any state:
  - Next state IDLE; no further O_dataValid.
  - O_bankReady and O_overrun are retained; a partial bank does not raise O_irq.
  - Abort and arm in the same cycle: abort wins, arm is ignored.
- Continuous mode (numBanks=0): the bank counter wraps silently; O_done never pulses.
- CTL_I_trigMode, CTL_I_threshold and CTL_I_numBanks are sampled on the arm cycle and held internally until the next arm.
- O_overrun stays set until the next accepted arm or reset.

Test Plan:
- Setup for all scenarios: DEPTH_LOG2=4, so 16 samples per bank.
- Immediate, 2 banks: arm (trigMode=0, numBanks=2), 40 valid samples 0..39 -> 1 O_bufRst pulse; O_data 0..31 each 1 cycle after input; O_irq with bank 0 after sample 15 and bank 1 after sample 31; O_done; samples 32..39 not strobed; O_bankReady=11.
- Threshold: arm (trigMode=1, threshold=0x0100, numBanks=1), samples 0x0010, 0xFF00 (-256), 0x0005 -> capture starts at 0xFF00, which becomes the first O_data; 0x0010 is never strobed.
- Overrun: continuous mode, no releases, 48 samples -> banks 0 and 1 fill, O_overrun=1, state STALL, O_dataValid stays 0. Release bank 0, then 16 more samples -> all written to bank 0, O_irq bank 0.
- Release timing: release bank 0 during bank-1 fill -> no stall, O_overrun stays 0, bank 0 refilled; release of a non-ready bank is ignored.
- Abort mid-bank: abort after 7 samples of bank 1 -> IDLE next cycle, no O_irq, O_bankReady=01 retained. Arm+abort in the same cycle -> stays IDLE, no O_bufRst.
- Async reset asserted mid-CAPTURE, away from a clock edge -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/acq_bank_scheduler.sv
// Capture sequencer for the dual-bank ADC sample buffer: arm/trigger, bank-aligned write
// gating, per-bank ready tracking, completion IRQ and overrun stall.
module acq_bank_scheduler #(
  parameter int unsigned DEPTH_LOG2 = 13,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             ADC_I_clk,
  input  logic             I_rst_n,
  input  logic             CTL_I_arm,
  input  logic             CTL_I_abort,
  input  logic             CTL_I_trigMode,
  input  logic [15:0]      CTL_I_threshold,
  input  logic [CNT_W-1:0] CTL_I_numBanks,
  input  logic             ADC_I_dataValid,
  input  logic [15:0]      ADC_I_data,
  input  logic [1:0]       BF_I_bankRelease,
  output logic             O_dataValid,
  output logic [15:0]      O_data,
  output logic             O_bufRst,
  output logic [1:0]       O_bankReady,
  output logic             O_irq,
  output logic             O_irqBank,
  output logic [1:0]       O_state,
  output logic             O_overrun,
  output logic             O_done
);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StArmed   = 2'b01,
    StCapture = 2'b10,
    StStall   = 2'b11
  } state_e;

  localparam logic [DEPTH_LOG2-1:0] IdxLast = '1;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  bank_q, bank_d;
  logic                  comp_q, comp_d;
  logic [1:0]            ready_q, ready_d;
  logic                  ovr_q, ovr_d;
  logic                  dv_q, dv_d;
  logic [15:0]           data_q, data_d;
  logic                  irq_q, irq_d;
  logic                  irq_bank_q, irq_bank_d;
  logic                  done_q, done_d;
  logic                  buf_rst_q, buf_rst_d;
  logic                  mode_q, mode_d;
  logic [15:0]           thr_q, thr_d;
  logic [CNT_W-1:0]      nb_q, nb_d;

  logic [16:0] sample_abs;
  logic        trig_hit;
  logic        nxt_bank;

  // 17-bit magnitude so that -32768 maps to 32768 rather than overflowing.
  assign sample_abs = ADC_I_data[15] ? (17'd0 - {ADC_I_data[15], ADC_I_data})
                                     : {1'b0, ADC_I_data};
  assign trig_hit   = !mode_q || (sample_abs >= {1'b0, thr_q});
  assign nxt_bank   = ~bank_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    bank_d     = bank_q;
    comp_d     = 1'b0;
    // Release applies first so a same-cycle completion set wins.
    ready_d    = ready_q & ~BF_I_bankRelease;
    ovr_d      = ovr_q;
    dv_d       = 1'b0;
    data_d     = data_q;
    irq_d      = 1'b0;
    irq_bank_d = irq_bank_q;
    done_d     = 1'b0;
    buf_rst_d  = 1'b0;
    mode_d     = mode_q;
    thr_d      = thr_q;
    nb_d       = nb_q;

    if (CTL_I_abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (CTL_I_arm) begin
            state_d   = StArmed;
            ready_d   = 2'b00;
            ovr_d     = 1'b0;
            idx_d     = '0;
            cnt_d     = '0;
            bank_d    = 1'b0;
            buf_rst_d = 1'b1;
            mode_d    = CTL_I_trigMode;
            thr_d     = CTL_I_threshold;
            nb_d      = CTL_I_numBanks;
          end
        end
        StArmed: begin
          if (ADC_I_dataValid && trig_hit) begin
            dv_d    = 1'b1;
            data_d  = ADC_I_data;
            idx_d   = DEPTH_LOG2'(1);
            state_d = StCapture;
          end
        end
        StCapture: begin
          if (comp_q) begin
            // Completion cycle: the previous write closed the current bank.
            irq_d            = 1'b1;
            irq_bank_d       = bank_q;
            ready_d[bank_q]  = 1'b1;
            cnt_d            = cnt_q + CNT_W'(1);
            if ((nb_q != '0) && (cnt_d == nb_q)) begin
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              bank_d = nxt_bank;
              if (ready_d[nxt_bank]) begin
                state_d = StStall;
                ovr_d   = 1'b1;
              end else if (ADC_I_dataValid) begin
                dv_d   = 1'b1;
                data_d = ADC_I_data;
                idx_d  = DEPTH_LOG2'(1);
              end
            end
          end else if (ADC_I_dataValid) begin
            dv_d   = 1'b1;
            data_d = ADC_I_data;
            idx_d  = idx_q + DEPTH_LOG2'(1);
            comp_d = (idx_q == IdxLast);
          end
        end
        StStall: begin
          if (!ready_d[bank_q]) begin
            state_d = StCapture;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge ADC_I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cnt_q      <= '0;
      bank_q     <= 1'b0;
      comp_q     <= 1'b0;
      ready_q    <= 2'b00;
      ovr_q      <= 1'b0;
      dv_q       <= 1'b0;
      data_q     <= '0;
      irq_q      <= 1'b0;
      irq_bank_q <= 1'b0;
      done_q     <= 1'b0;
      buf_rst_q  <= 1'b0;
      mode_q     <= 1'b0;
      thr_q      <= '0;
      nb_q       <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      bank_q     <= bank_d;
      comp_q     <= comp_d;
      ready_q    <= ready_d;
      ovr_q      <= ovr_d;
      dv_q       <= dv_d;
      data_q     <= data_d;
      irq_q      <= irq_d;
      irq_bank_q <= irq_bank_d;
      done_q     <= done_d;
      buf_rst_q  <= buf_rst_d;
      mode_q     <= mode_d;
      thr_q      <= thr_d;
      nb_q       <= nb_d;
    end
  end

  assign O_dataValid = dv_q;
  assign O_data      = data_q;
  assign O_bufRst    = buf_rst_q;
  assign O_bankReady = ready_q;
  assign O_irq       = irq_q;
  assign O_irqBank   = irq_bank_q;
  assign O_state     = state_q;
  assign O_overrun   = ovr_q;
  assign O_done      = done_q;

endmodule

// File: tb/tb_acq_bank_scheduler.sv
// Scoreboard bench for acq_bank_scheduler with 16-sample banks: expected writes and IRQs are
// queued with their due cycle when stimulus is driven and checked every falling edge.
module tb_acq_bank_scheduler;

  logic        ADC_I_clk;
  logic        I_rst_n;
  logic        CTL_I_arm;
  logic        CTL_I_abort;
  logic        CTL_I_trigMode;
  logic [15:0] CTL_I_threshold;
  logic [7:0]  CTL_I_numBanks;
  logic        ADC_I_dataValid;
  logic [15:0] ADC_I_data;
  logic [1:0]  BF_I_bankRelease;
  logic        O_dataValid;
  logic [15:0] O_data;
  logic        O_bufRst;
  logic [1:0]  O_bankReady;
  logic        O_irq;
  logic        O_irqBank;
  logic [1:0]  O_state;
  logic        O_overrun;
  logic        O_done;

  acq_bank_scheduler #(
    .DEPTH_LOG2(4),
    .CNT_W     (8)
  ) u_dut (
    .ADC_I_clk       (ADC_I_clk),
    .I_rst_n         (I_rst_n),
    .CTL_I_arm       (CTL_I_arm),
    .CTL_I_abort     (CTL_I_abort),
    .CTL_I_trigMode  (CTL_I_trigMode),
    .CTL_I_threshold (CTL_I_threshold),
    .CTL_I_numBanks  (CTL_I_numBanks),
    .ADC_I_dataValid (ADC_I_dataValid),
    .ADC_I_data      (ADC_I_data),
    .BF_I_bankRelease(BF_I_bankRelease),
    .O_dataValid     (O_dataValid),
    .O_data          (O_data),
    .O_bufRst        (O_bufRst),
    .O_bankReady     (O_bankReady),
    .O_irq           (O_irq),
    .O_irqBank       (O_irqBank),
    .O_state         (O_state),
    .O_overrun       (O_overrun),
    .O_done          (O_done)
  );

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_data_t;

  typedef struct {
    logic bank;
    int   cyc;
  } exp_irq_t;

  exp_data_t dq[$];
  exp_irq_t  iq[$];
  int n_vec    = 0;
  int n_err    = 0;
  int cyc      = 0;
  int n_bufrst = 0;
  int n_done   = 0;

  initial ADC_I_clk = 1'b0;
  always #5 ADC_I_clk = ~ADC_I_clk;
  always @(posedge ADC_I_clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor: every strobe and IRQ must match the head of its queue, on the due cycle.
  always @(negedge ADC_I_clk) begin
    if (I_rst_n) begin
      logic exp_dv;
      logic exp_irq;
      while (dq.size() > 0 && dq[0].cyc < cyc) begin
        check_eq("dv_late", cyc, dq[0].cyc);
        void'(dq.pop_front());
      end
      exp_dv = (dq.size() > 0) && (dq[0].cyc == cyc);
      check_eq("dv", {31'd0, O_dataValid}, {31'd0, exp_dv});
      if (exp_dv) begin
        if (O_dataValid) check_eq("data", {16'd0, O_data}, {16'd0, dq[0].data});
        void'(dq.pop_front());
      end
      while (iq.size() > 0 && iq[0].cyc < cyc) begin
        check_eq("irq_late", cyc, iq[0].cyc);
        void'(iq.pop_front());
      end
      exp_irq = (iq.size() > 0) && (iq[0].cyc == cyc);
      check_eq("irq", {31'd0, O_irq}, {31'd0, exp_irq});
      if (exp_irq) begin
        if (O_irq) check_eq("irq_bank", {31'd0, O_irqBank}, {31'd0, iq[0].bank});
        void'(iq.pop_front());
      end
      if (O_bufRst) n_bufrst++;
      if (O_done) n_done++;
    end
  end

  task automatic tick();
    @(posedge ADC_I_clk);
    #1;
  endtask

  task automatic arm_cmd(input logic mode, input logic [15:0] thr, input logic [7:0] nb);
    CTL_I_arm       = 1'b1;
    CTL_I_trigMode  = mode;
    CTL_I_threshold = thr;
    CTL_I_numBanks  = nb;
    tick();
    CTL_I_arm = 1'b0;
  endtask

  task automatic push_d(input logic [15:0] d);
    dq.push_back('{data: d, cyc: cyc + 1});
  endtask

  task automatic push_irq(input logic b);
    iq.push_back('{bank: b, cyc: cyc + 2});
  endtask

  task automatic drive(input logic [15:0] d);
    ADC_I_dataValid = 1'b1;
    ADC_I_data      = d;
    tick();
  endtask

  task automatic idle(input int n);
    ADC_I_dataValid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic abort_cmd();
    CTL_I_abort = 1'b1;
    tick();
    CTL_I_abort = 1'b0;
  endtask

  initial begin
    I_rst_n          = 1'b0;
    CTL_I_arm        = 1'b0;
    CTL_I_abort      = 1'b0;
    CTL_I_trigMode   = 1'b0;
    CTL_I_threshold  = '0;
    CTL_I_numBanks   = '0;
    ADC_I_dataValid  = 1'b0;
    ADC_I_data       = '0;
    BF_I_bankRelease = 2'b00;
    repeat (3) tick();
    check_eq("reset_outputs", {7'd0, O_dataValid, O_data, O_bufRst, O_bankReady, O_irq,
                               O_irqBank, O_overrun, O_done}, 32'd0);
    check_eq("reset_state", {30'd0, O_state}, 32'd0);
    I_rst_n = 1'b1;
    tick();

    // Immediate trigger, two banks; config inputs changed after arm must not matter.
    arm_cmd(1'b0, 16'h0000, 8'd2);
    check_eq("arm_bufrst", {31'd0, O_bufRst}, 32'd1);
    check_eq("arm_state", {30'd0, O_state}, 32'd1);
    CTL_I_numBanks  = 8'd1;
    CTL_I_trigMode  = 1'b1;
    CTL_I_threshold = 16'h7FFF;
    for (int i = 0; i < 40; i++) begin
      if (i < 32) push_d(16'(i));
      if (i == 15) push_irq(1'b0);
      if (i == 31) push_irq(1'b1);
      drive(16'(i));
    end
    idle(3);
    check_eq("s1_done", n_done, 1);
    check_eq("s1_ready", {30'd0, O_bankReady}, 32'd3);
    check_eq("s1_state", {30'd0, O_state}, 32'd0);
    check_eq("s1_bufrst", n_bufrst, 1);

    // Threshold trigger; a negative sample at exactly the threshold starts capture.
    arm_cmd(1'b1, 16'h0100, 8'd1);
    check_eq("s2_ready_clr", {30'd0, O_bankReady}, 32'd0);
    drive(16'h0010);
    push_d(16'hFF00);
    drive(16'hFF00);
    push_d(16'h0005);
    drive(16'h0005);
    for (int k = 2; k < 16; k++) begin
      push_d(16'h1000 + 16'(k));
      if (k == 15) push_irq(1'b0);
      drive(16'h1000 + 16'(k));
    end
    idle(3);
    check_eq("s2_done", n_done, 2);
    check_eq("s2_ready", {30'd0, O_bankReady}, 32'd1);

    // Magnitude boundary: |-32768| = 32768 meets a 0x8000 threshold, 32767 does not.
    arm_cmd(1'b1, 16'h8000, 8'd1);
    drive(16'h7FFF);
    check_eq("s2b_armed", {30'd0, O_state}, 32'd1);
    push_d(16'h8000);
    drive(16'h8000);
    idle(1);
    check_eq("s2b_capture", {30'd0, O_state}, 32'd2);
    abort_cmd();
    check_eq("s2b_abort", {30'd0, O_state}, 32'd0);

    // Continuous mode overrun, then recovery after releasing bank 0.
    arm_cmd(1'b0, 16'h0000, 8'd0);
    for (int i = 0; i < 48; i++) begin
      if (i < 32) push_d(16'h2000 + 16'(i));
      if (i == 15) push_irq(1'b0);
      if (i == 31) push_irq(1'b1);
      drive(16'h2000 + 16'(i));
    end
    idle(1);
    check_eq("s3_stall", {30'd0, O_state}, 32'd3);
    check_eq("s3_overrun", {31'd0, O_overrun}, 32'd1);
    check_eq("s3_ready", {30'd0, O_bankReady}, 32'd3);
    BF_I_bankRelease = 2'b01;
    tick();
    BF_I_bankRelease = 2'b00;
    check_eq("s3_resume", {30'd0, O_state}, 32'd2);
    check_eq("s3_ready_rel", {30'd0, O_bankReady}, 32'd2);
    for (int i = 0; i < 16; i++) begin
      push_d(16'h3000 + 16'(i));
      if (i == 15) push_irq(1'b0);
      drive(16'h3000 + 16'(i));
    end
    idle(3);
    check_eq("s3_stall2", {30'd0, O_state}, 32'd3);
    abort_cmd();
    check_eq("s3_abort", {30'd0, O_state}, 32'd0);
    check_eq("s3_ovr_kept", {31'd0, O_overrun}, 32'd1);

    // Timely release avoids a stall; releasing a non-ready bank changes nothing.
    arm_cmd(1'b0, 16'h0000, 8'd0);
    check_eq("s4_ovr_clr", {31'd0, O_overrun}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      BF_I_bankRelease = (i == 20) ? 2'b01 : (i == 22) ? 2'b10 : 2'b00;
      push_d(16'h4000 + 16'(i));
      if (i == 15) push_irq(1'b0);
      if (i == 31) push_irq(1'b1);
      drive(16'h4000 + 16'(i));
    end
    BF_I_bankRelease = 2'b00;
    idle(2);
    check_eq("s4_overrun", {31'd0, O_overrun}, 32'd0);
    check_eq("s4_state", {30'd0, O_state}, 32'd2);
    check_eq("s4_ready", {30'd0, O_bankReady}, 32'd2);
    BF_I_bankRelease = 2'b10;
    tick();
    BF_I_bankRelease = 2'b00;
    check_eq("s4_ready_rel", {30'd0, O_bankReady}, 32'd0);
    abort_cmd();

    // Abort part-way through bank 1; then arm and abort together.
    arm_cmd(1'b0, 16'h0000, 8'd0);
    for (int i = 0; i < 23; i++) begin
      push_d(16'h5000 + 16'(i));
      if (i == 15) push_irq(1'b0);
      drive(16'h5000 + 16'(i));
    end
    CTL_I_abort = 1'b1;
    drive(16'hDEAD);
    CTL_I_abort = 1'b0;
    check_eq("s5_idle", {30'd0, O_state}, 32'd0);
    idle(3);
    check_eq("s5_ready", {30'd0, O_bankReady}, 32'd1);
    CTL_I_arm   = 1'b1;
    CTL_I_abort = 1'b1;
    tick();
    CTL_I_arm   = 1'b0;
    CTL_I_abort = 1'b0;
    check_eq("s5_armabort_state", {30'd0, O_state}, 32'd0);
    check_eq("s5_armabort_bufrst", {31'd0, O_bufRst}, 32'd0);
    tick();
    check_eq("s5_ready_kept", {30'd0, O_bankReady}, 32'd1);
    check_eq("s5_bufrst_cnt", n_bufrst, 6);

    // Asynchronous reset between clock edges while capturing.
    arm_cmd(1'b0, 16'h0000, 8'd0);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) push_d(16'h0A00 + 16'(i));
      drive(16'h0A00 + 16'(i));
    end
    #2;
    I_rst_n = 1'b0;
    #1;
    check_eq("arst_outputs", {7'd0, O_dataValid, O_data, O_bufRst, O_bankReady, O_irq,
                              O_irqBank, O_overrun, O_done}, 32'd0);
    check_eq("arst_state", {30'd0, O_state}, 32'd0);
    ADC_I_dataValid = 1'b0;
    #10;
    I_rst_n = 1'b1;
    idle(3);
    check_eq("end_state", {30'd0, O_state}, 32'd0);
    check_eq("dq_empty", dq.size(), 0);
    check_eq("iq_empty", iq.size(), 0);
    check_eq("done_total", n_done, 2);
    check_eq("bufrst_total", n_bufrst, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
